// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared definitions for the boot-time instruction memory loader:
//            loader state encoding and frame header width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Width of the little-endian word-count header at the start of a frame.
    localparam int FRAME_HDR_W = 16;

    typedef enum logic [2:0] {
        LOADER_LEN_LO = 3'd0,
        LOADER_LEN_HI = 3'd1,
        LOADER_DATA   = 3'd2,
        LOADER_DONE   = 3'd3,
        LOADER_ERR    = 3'd4
    } loader_state_t;

    // True in the states that consume bytes from the stream.
    function automatic logic is_loading(input loader_state_t s);
        return (s == LOADER_LEN_LO) || (s == LOADER_LEN_HI) || (s == LOADER_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_byte_packer
// Purpose  : Packs an accepted byte stream into little-endian 32-bit words.
//            The first three bytes of a word collect in a lane register; the
//            fourth byte completes the word into a separate output register,
//            so the lanes are free again for the next word while the
//            completed word is being written.
// Ports    : clk          system clock
//            rst          synchronous active-low reset
//            clr          restart assembly at lane 0 (drops partial bytes)
//            byte_accept  byte_data is consumed this cycle
//            byte_data    stream byte
//            byte_idx     lane the next accepted byte will fill
//            word_valid   one-cycle pulse, word holds a completed word
//            word         last completed word (holds between pulses)
// Revision : 1.0  initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_accept,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] r_lanes;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lanes      <= 24'd0;
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (clr) begin
                r_lanes <= 24'd0;
                r_idx   <= 2'd0;
            end else if (byte_accept) begin
                case (r_idx)
                    2'd0:    r_lanes[7:0]   <= byte_data;
                    2'd1:    r_lanes[15:8]  <= byte_data;
                    2'd2:    r_lanes[23:16] <= byte_data;
                    default: begin
                        // Fourth byte: hand the finished word off directly.
                        r_word       <= {byte_data, r_lanes};
                        r_word_valid <= 1'b1;
                    end
                endcase
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign byte_idx   = r_idx;
    assign word_valid = r_word_valid;
    assign word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time program loader. Receives a frame (16-bit LE word
//            count N, then 4*N bytes, each word LSB first) over a valid/ready
//            byte stream, writes the words to instruction memory from
//            address 0 upward, and holds the core in reset until the last
//            word has been written.
// Ports    : clk          system clock
//            rst          synchronous active-low reset
//            in_valid     byte-stream valid
//            in_data      byte-stream data
//            in_ready     loader can accept a byte this cycle
//            reload       request a new program load (only in DONE)
//            imem_we      instruction memory write enable (one-cycle pulses)
//            imem_addr    instruction memory word address
//            imem_wdata   instruction word
//            core_rst     active-low core reset
//            busy/done/err state indications
// Revision : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTRUCTIONS = 256,
    parameter int AW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [FRAME_HDR_W-1:0] c_max_words = FRAME_HDR_W'(INSTRUCTIONS);

    loader_state_t           r_state;
    loader_state_t           w_next_state;
    logic [7:0]              r_len_lo;
    logic [FRAME_HDR_W-1:0]  r_len;
    logic [FRAME_HDR_W-1:0]  r_word_cnt;
    logic [AW-1:0]           r_addr;
    logic                    r_core_rst;

    logic                    w_accept;
    logic                    w_data_accept;
    logic                    w_last_lane;
    logic                    w_last_word;
    logic                    w_clr;
    logic [FRAME_HDR_W-1:0]  w_hdr;
    logic [1:0]              w_byte_idx;
    logic                    w_word_valid;
    logic [31:0]             w_word;

    assign w_accept      = in_valid && in_ready;
    assign w_hdr         = {in_data, r_len_lo};
    assign w_data_accept = w_accept && (r_state == LOADER_DATA);
    assign w_last_lane   = w_data_accept && (w_byte_idx == 2'd3);
    assign w_last_word   = w_last_lane && (r_word_cnt == (r_len - 16'd1));

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (w_clr),
        .byte_accept (w_data_accept),
        .byte_data   (in_data),
        .byte_idx    (w_byte_idx),
        .word_valid  (w_word_valid),
        .word        (w_word)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LOADER_LEN_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        in_ready     = is_loading(r_state);
        busy         = is_loading(r_state);
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            LOADER_LEN_LO: begin
                if (w_accept) begin
                    w_next_state = LOADER_LEN_HI;
                end
            end
            LOADER_LEN_HI: begin
                if (w_accept) begin
                    if (w_hdr == '0) begin
                        w_next_state = LOADER_DONE;
                    end else if (w_hdr > c_max_words) begin
                        w_next_state = LOADER_ERR;
                    end else begin
                        w_next_state = LOADER_DATA;
                        w_clr        = 1'b1;
                    end
                end
            end
            LOADER_DATA: begin
                // The final word's write pulse lands in the first DONE cycle.
                if (w_last_word) begin
                    w_next_state = LOADER_DONE;
                end
            end
            LOADER_DONE: begin
                done = 1'b1;
                if (reload) begin
                    w_next_state = LOADER_LEN_LO;
                    w_clr        = 1'b1;
                end
            end
            LOADER_ERR: begin
                err = 1'b1;
            end
            default: begin
                w_next_state = LOADER_LEN_LO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Length, word counter, write address and core reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len_lo   <= 8'd0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_core_rst <= 1'b0;
        end else begin
            if ((r_state == LOADER_LEN_LO) && w_accept) begin
                r_len_lo <= in_data;
            end
            if ((r_state == LOADER_LEN_HI) && w_accept) begin
                r_len      <= w_hdr;
                r_word_cnt <= '0;
            end
            // Address is latched alongside the packer's word register so both
            // appear together on the write cycle and hold afterwards.
            if (w_last_lane) begin
                r_addr     <= r_word_cnt[AW-1:0];
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            if ((r_state == LOADER_DONE) && reload) begin
                r_len_lo   <= 8'd0;
                r_len      <= '0;
                r_word_cnt <= '0;
            end
            // Registered from the state so the release trails entry into DONE
            // by one cycle, i.e. follows the final write pulse.
            r_core_rst <= (r_state == LOADER_DONE) && !reload;
        end
    end

    assign imem_we    = w_word_valid;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign core_rst   = r_core_rst;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Expected memory writes are
//            queued as frames are built and popped as imem_we pulses appear.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         n_checks;
    int         n_pass;

    imem_loader #(
        .INSTRUCTIONS (256),
        .AW           (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and any
    // write pulse is checked against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic push_hdr(input logic [15:0] n);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [7:0] addr, input logic [31:0] data);
        wr_t e;
        tx_q.push_back(data[7:0]);
        tx_q.push_back(data[15:8]);
        tx_q.push_back(data[23:16]);
        tx_q.push_back(data[31:24]);
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Sends every queued byte. With gap=1 an idle cycle precedes each byte so
    // the final tick is always the accepting edge of the last byte.
    task automatic send_all(input bit gap);
        while (tx_q.size() > 0) begin
            if (gap) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = tx_q.pop_front();
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;

        // Reset state
        do_reset();
        chk("rst_we",       32'(imem_we),  32'd0);
        chk("rst_addr",     32'(imem_addr), 32'd0);
        chk("rst_wdata",    imem_wdata,    32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        tick();
        chk("rst_ready",    32'(in_ready), 32'd1);
        chk("rst_busy",     32'(busy),     32'd1);

        // Two-word frame, valid held high
        push_hdr(16'd2);
        push_word(8'd0, 32'h0010_0513);
        push_word(8'd1, 32'h0020_0593);
        send_all(1'b0);
        chk("t1_done",      32'(done),     32'd1);
        chk("t1_ready",     32'(in_ready), 32'd0);
        chk("t1_core_rst0", 32'(core_rst), 32'd0);
        tick();
        chk("t1_core_rst1", 32'(core_rst), 32'd1);
        chk("t1_we_idle",   32'(imem_we),  32'd0);
        chk("t1_addr_hold", 32'(imem_addr), 32'd1);
        chk("t1_data_hold", imem_wdata,    32'h0020_0593);
        chk("t1_pending",   32'(exp_q.size()), 32'd0);

        // Same frame, valid toggling
        do_reset();
        push_hdr(16'd2);
        push_word(8'd0, 32'h0010_0513);
        push_word(8'd1, 32'h0020_0593);
        send_all(1'b1);
        chk("t2_done",      32'(done),     32'd1);
        tick();
        chk("t2_core_rst1", 32'(core_rst), 32'd1);
        chk("t2_pending",   32'(exp_q.size()), 32'd0);

        // Zero-length frame
        do_reset();
        push_hdr(16'd0);
        send_all(1'b0);
        chk("t3_done",      32'(done),     32'd1);
        chk("t3_core_rst0", 32'(core_rst), 32'd0);
        tick();
        chk("t3_core_rst1", 32'(core_rst), 32'd1);
        tick();

        // Oversize frame: 257 words
        do_reset();
        push_hdr(16'h0101);
        send_all(1'b0);
        chk("t4_err",       32'(err),      32'd1);
        chk("t4_ready",     32'(in_ready), 32'd0);
        chk("t4_busy",      32'(busy),     32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        reload   = 1'b1;
        tick();
        reload   = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t4_err_stays", 32'(err),      32'd1);
        chk("t4_core_rst",  32'(core_rst), 32'd0);
        chk("t4_done",      32'(done),     32'd0);
        do_reset();
        tick();
        chk("t4_err_clr",   32'(err),      32'd0);
        chk("t4_ready_back", 32'(in_ready), 32'd1);

        // Reset after 6 of 8 data bytes, then a one-word frame
        push_hdr(16'd2);
        push_word(8'd0, 32'h4433_2211);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        send_all(1'b0);
        chk("t5_busy_mid",  32'(busy),     32'd1);
        do_reset();
        chk("t5_wdata_clr", imem_wdata,    32'd0);
        push_hdr(16'd1);
        push_word(8'd0, 32'h0099_8877);
        send_all(1'b0);
        chk("t5_done",      32'(done),     32'd1);
        tick();
        chk("t5_core_rst1", 32'(core_rst), 32'd1);
        chk("t5_pending",   32'(exp_q.size()), 32'd0);

        // Reload from DONE
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("t6_core_rst0", 32'(core_rst), 32'd0);
        chk("t6_done0",     32'(done),     32'd0);
        chk("t6_busy",      32'(busy),     32'd1);
        push_hdr(16'd1);
        push_word(8'd0, 32'hDDCC_BBAA);
        send_all(1'b0);
        chk("t6_done1",     32'(done),     32'd1);
        chk("t6_core_rst_hold", 32'(core_rst), 32'd0);
        tick();
        chk("t6_core_rst1", 32'(core_rst), 32'd1);
        chk("t6_pending",   32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle core's instruction ROM.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into instruction memory.
- Holds the core in reset until the whole program is written, then releases it.
- Replaces the static hex-file image when a program is loaded at run time.

Parameters:
- INSTRUCTIONS, 256, instruction memory depth in words; maximum accepted program length.
- AW, 8, instruction memory word-address width; must satisfy 2**AW >= INSTRUCTIONS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle request to load a new program; honoured only in DONE.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  AW  instruction memory word address.
- imem_wdata  output  32  instruction word to write.
- core_rst  output  1  active-low reset to the core; low holds the core in reset.
- busy  output  1  high in LEN_LO, LEN_HI and DATA.
- done  output  1  high in DONE.
- err  output  1  high in ERR.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=LEN_LO; byte index, word counter, length register and assembly register cleared.
  - imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, err=0.
  - Reset mid-load discards all partial state. Words already written stay in memory but are not trusted.
- Handshake: a byte is accepted when in_valid && in_ready at a rising edge. in_data must be stable while in_valid=1. There is no backpressure beyond in_ready.
- in_ready=1 in LEN_LO, LEN_HI and DATA. in_ready=0 in DONE and ERR.
- Frame format: 16-bit little-endian word count N (LEN_LO byte, then LEN_HI byte), followed by 4*N data bytes. Each word is sent LSB first.
- States and transitions:
  - LEN_LO: on accept, len[7:0]=in_data, go to LEN_HI.
  - LEN_HI: on accept, form N={in_data,len[7:0]}.
    - N=0 goes to DONE.
    - N>INSTRUCTIONS goes to ERR.
    - Otherwise go to DATA with word counter=0 and byte index=0.
  - DATA: each accepted byte goes into assembly lane byte_idx (bits 8*i+7:8*i); byte_idx increments modulo 4.
    - On the 4th byte, the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=word counter. The word counter then increments.
    - The write lasts exactly one cycle. Bytes may still be accepted during the write cycle; the assembly register is double-buffered so nothing stalls.
    - When the 4th byte of word N-1 is accepted, go to DONE. That word's imem_we pulse occurs in the first DONE cycle.
  - DONE: done=1. core_rst rises to 1 one cycle after the final imem_we pulse, so the core never fetches before the last write lands.
    - reload=1 drives core_rst=0 and done=0 on the next cycle and returns to LEN_LO with counters cleared.
  - ERR: err=1, core_rst=0, no writes. Only rst exits ERR; reload is ignored.
- Outside of write pulses: imem_we=0. imem_addr and imem_wdata hold their last values.
- Address arithmetic: imem_addr is the low AW bits of the word counter. Because N<=INSTRUCTIONS, the address never wraps.
- in_valid in DONE or ERR: the byte is not accepted and no state change occurs.
- reload outside DONE: ignored.

Decomposition:
- Shared package holds:
  - state encoding constants LOADER_LEN_LO, LOADER_LEN_HI, LOADER_DATA, LOADER_DONE, LOADER_ERR;
  - the frame header width constant (16).
- One natural sub-module, byte_packer. It takes the byte stream plus handshake and emits a 32-bit word with a one-cycle word_valid pulse and a clear input.
- The FSM, counters and core_rst logic stay in imem_loader.

Test Plan:
- Reset release, then bytes 02 00, 13 05 10 00, 93 05 20 00 with in_valid held high -> imem_we pulses at addr 0 with 0x00100513 and at addr 1 with 0x00200593. done=1; core_rst=1 one cycle after the second pulse.
- Same frame with in_valid toggled 1/0 each cycle -> identical writes and data. No byte is lost or duplicated.
- Header 00 00 -> no imem_we. DONE is reached immediately after the LEN_HI accept, then core_rst=1.
- Header 01 01 (257 words, INSTRUCTIONS=256) -> err=1, in_ready=0, core_rst stays 0, no writes. rst pulse returns to LEN_LO.
- rst asserted after 6 of 8 data bytes, then a full 1-word frame sent -> the single word is written at addr 0. No stale bytes from the aborted load appear.
- In DONE, pulse reload and send a 1-word frame AA BB CC DD -> core_rst drops the next cycle, then imem_we at addr 0 with 0xDDCCBBAA, then DONE again.
